// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: FSM state encoding and sizing helpers shared by the LSU arbiter.
// Contents:
//   state_e   - arbiter FSM states (IDLE, ISSUE, WAIT)
//   cnt_width - bits needed by the watchdog counter, which counts 0..TIMEOUT-1
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker for the LSU arbiter.
// Ports:
//   req_i        - request vector, one bit per requester
//   last_grant_i - index of the most recent winner; priority starts one above it
//   grant_o      - one-hot grant of the highest-priority requester (0 if none)
//   grant_idx_o  - binary index of the granted requester (0 if none)
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o
);

    logic [IW:0] c;

    // Scan from lowest to highest priority so the last hit wins; one extra bit
    // on c keeps last_grant+k from overflowing before the modulo wrap.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        c           = '0;
        for (int k = NREQ; k >= 1; k--) begin
            c = {1'b0, last_grant_i} + (IW+1)'(k);
            c = (c >= (IW+1)'(NREQ)) ? c - (IW+1)'(NREQ) : c;
            if (req_i[c[IW-1:0]]) begin
                grant_o             = '0;
                grant_o[c[IW-1:0]]  = 1'b1;
                grant_idx_o         = c[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin sharing of one load/store unit between NREQ requesters.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_valid/req_ready - per-requester valid/ready handshake (ready is one-hot)
//   req_write       - per-requester store flag (0 = load)
//   req_addr/req_wdata - packed per-requester address and store data
//   resp_valid      - one-hot, one-cycle completion pulse to the owner
//   resp_rdata      - load data (0 for stores and timeouts), qualified by resp_valid
//   resp_err        - watchdog expiry, qualified by resp_valid
//   lsu_mem_read/lsu_mem_write - single-cycle LSU strobes
//   lsu_address/lsu_write_data - latched payload presented to the LSU
//   lsu_read_data/lsu_ready    - LSU load data and completion
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*WIDTH-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  resp_err,
    output logic                  lsu_mem_read,
    output logic                  lsu_mem_write,
    output logic [WIDTH-1:0]      lsu_address,
    output logic [WIDTH-1:0]      lsu_write_data,
    input  logic [WIDTH-1:0]      lsu_read_data,
    input  logic                  lsu_ready
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(TIMEOUT);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, last_q, last_d, gnt_idx;
    logic              write_q, write_d, err_q, err_d, hs;
    logic [WIDTH-1:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt, rvalid_q, rvalid_d;
    logic [WIDTH-1:0]  addr_a  [NREQ];
    logic [WIDTH-1:0]  wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*WIDTH +: WIDTH];
        assign wdata_a[i] = req_wdata[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (gnt),
        .grant_idx_o  (gnt_idx)
    );

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign req_ready      = (state_q == IDLE && !rst) ? gnt : '0;
    assign hs             = |(req_valid & req_ready);
    assign lsu_mem_read   = (state_q == ISSUE) && !write_q;
    assign lsu_mem_write  = (state_q == ISSUE) && write_q;
    assign lsu_address    = addr_q;
    assign lsu_write_data = wdata_q;
    assign resp_valid     = rvalid_q;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rvalid_d = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (hs) begin
                idx_d   = gnt_idx;
                last_d  = gnt_idx;
                write_d = req_write[gnt_idx];
                addr_d  = addr_a[gnt_idx];
                wdata_d = wdata_a[gnt_idx];
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (lsu_ready || cnt_q == CW'(TIMEOUT-1)) begin
                // A ready arriving on the last watchdog cycle still completes normally.
                rvalid_d = NREQ'(1) << idx_q;
                rdata_d  = (lsu_ready && !write_q) ? lsu_read_data : '0;
                err_d    = !lsu_ready;
                state_d  = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= IW'(NREQ-1);
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: scoreboard bench for lsu_arbiter with a behavioural LSU and round-robin model.
module tb_lsu_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 15;

    typedef struct {
        int          idx;
        logic [W-1:0] rd;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic        w;
        logic [W-1:0] a;
        logic [W-1:0] wd;
        int          d;
        bit          to;
        bit          st;
        int          hs;
    } op_t;

    logic           clk, rst;
    logic [N-1:0]   req_valid, req_write, req_ready, resp_valid;
    logic [N*W-1:0] req_addr, req_wdata;
    logic [W-1:0]   resp_rdata, lsu_address, lsu_write_data, lsu_read_data;
    logic           resp_err, lsu_mem_read, lsu_mem_write, lsu_ready;

    lsu_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .lsu_mem_read   (lsu_mem_read),
        .lsu_mem_write  (lsu_mem_write),
        .lsu_address    (lsu_address),
        .lsu_write_data (lsu_write_data),
        .lsu_read_data  (lsu_read_data),
        .lsu_ready      (lsu_ready)
    );

    int checks = 0, errors = 0, cyc = 0;
    bit in_rst = 1, stray_idle = 0;
    int f_d = 0, f_to = 0, f_st = 0, gen_prob = 0, gen_left = 0, last = N - 1;
    bit pv [N];
    bit pw [N];
    logic [W-1:0] pa [N];
    logic [W-1:0] pd [N];
    logic [W-1:0] ref_mem [16];
    logic [W-1:0] lsu_mem [16];
    exp_t sb [$];
    op_t  lq [$];
    int   order [$];
    int   ocyc [$];
    bit   lsu_active = 0, lsu_w = 0;
    int   lsu_cnt = 0;
    logic [3:0] lsu_a = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic void post(input int i, input bit w, input logic [W-1:0] a, input logic [W-1:0] d);
        pv[i] = 1'b1;
        pw[i] = w;
        pa[i] = a;
        pd[i] = d;
    endfunction

    function automatic void set_mode(input int d, input int t, input int s);
        f_d  = d;
        f_to = t;
        f_st = s;
    endfunction

    function automatic bit any_pending();
        bit r = 0;
        for (int i = 0; i < N; i++) r |= pv[i];
        return r;
    endfunction

    task automatic outs_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 0);
        chk({tag, "_resp_rdata"}, 64'(resp_rdata), 0);
        chk({tag, "_resp_err"}, 64'(resp_err), 0);
        chk({tag, "_strobes"}, 64'({lsu_mem_read, lsu_mem_write}), 0);
        chk({tag, "_lsu_address"}, 64'(lsu_address), 0);
        chk({tag, "_lsu_wdata"}, 64'(lsu_write_data), 0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((any_pending() || gen_left != 0 || sb.size() != 0 || lq.size() != 0 || lsu_active) && n < bound);
        if (n >= bound) chk("drain_timeout", 64'(n), 64'(bound - 1));
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver plus round-robin reference: expected grant is the first
    // valid requester after the last winner, and only while nothing is outstanding.
    initial begin : drv
        int g, j, d;
        bit to, st;
        logic [N-1:0] eg;
        logic [W-1:0] rd;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i]         = pv[i];
                req_write[i]         = pw[i];
                req_addr[i*W +: W]   = pa[i];
                req_wdata[i*W +: W]  = pd[i];
            end
            #1;
            if (!in_rst) begin
                g = -1;
                if (sb.size() == 0)
                    for (int k = 1; k <= N; k++) begin
                        j = (last + k) % N;
                        if (g < 0 && pv[j]) g = j;
                    end
                eg = '0;
                if (g >= 0) eg[g] = 1'b1;
                chk("req_ready", 64'(req_ready), 64'(eg));
                if (g >= 0) begin
                    d  = (f_d >= 0) ? f_d : (($urandom % 16 == 0) ? TO - 1 : int'($urandom_range(0, 3)));
                    to = (f_to >= 0) ? bit'(f_to) : ($urandom % 12 == 0);
                    st = (f_st >= 0) ? bit'(f_st) : ($urandom % 8 == 0);
                    rd = (to || pw[g]) ? '0 : ref_mem[pa[g][3:0]];
                    if (!to && pw[g]) ref_mem[pa[g][3:0]] = pd[g];
                    sb.push_back('{idx: g, rd: rd, err: to, due: to ? cyc + 2 + TO : cyc + 3 + d});
                    lq.push_back('{w: pw[g], a: pa[g], wd: pd[g], d: d, to: to, st: st, hs: cyc});
                    order.push_back(g);
                    ocyc.push_back(cyc);
                    pv[g] = 1'b0;
                    last  = g;
                end
                for (int i = 0; i < N; i++)
                    if (!pv[i] && gen_left > 0 && int'($urandom_range(1, 100)) <= gen_prob) begin
                        post(i, bit'($urandom % 2), W'($urandom_range(0, 15)), $urandom);
                        gen_left--;
                    end
            end
        end
    end

    // Behavioural LSU: checks each strobe against the accepted op, then answers
    // after the chosen delay, or never for a watchdog test.
    initial begin : lsu
        op_t m;
        lsu_ready     = 1'b0;
        lsu_read_data = '0;
        forever begin
            @(negedge clk);
            lsu_ready     = 1'b0;
            lsu_read_data = '0;
            if (in_rst) begin
                lsu_active = 0;
            end else begin
                if (lsu_active) begin
                    if (lsu_cnt == 0) begin
                        lsu_ready     = 1'b1;
                        lsu_read_data = lsu_w ? $urandom : lsu_mem[lsu_a];
                        lsu_active    = 0;
                    end else begin
                        lsu_cnt--;
                    end
                end else if (stray_idle || (sb.size() == 0 && $urandom % 10 == 0)) begin
                    lsu_ready     = 1'b1;
                    lsu_read_data = $urandom;
                end
                if (lsu_mem_read || lsu_mem_write) begin
                    if (lq.size() == 0) begin
                        chk("strobe_unexpected", 64'({lsu_mem_read, lsu_mem_write}), 0);
                    end else begin
                        m = lq.pop_front();
                        chk("strobe_kind", 64'({lsu_mem_read, lsu_mem_write}), 64'({!m.w, m.w}));
                        chk("strobe_cycle", 64'(cyc), 64'(m.hs + 1));
                        chk("lsu_address", 64'(lsu_address), 64'(m.a));
                        if (m.w) chk("lsu_write_data", 64'(lsu_write_data), 64'(m.wd));
                        if (m.st) begin
                            lsu_ready     = 1'b1;
                            lsu_read_data = $urandom;
                        end
                        if (!m.to) begin
                            if (m.w) lsu_mem[m.a[3:0]] = m.wd;
                            lsu_active = 1;
                            lsu_cnt    = m.d;
                            lsu_w      = m.w;
                            lsu_a      = m.a[3:0];
                        end
                    end
                end
            end
        end
    end

    // Response monitor: every completion pops the scoreboard.
    initial begin : mon
        exp_t e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                if (resp_valid != '0) begin
                    if (sb.size() == 0) begin
                        chk("resp_unexpected", 64'(resp_valid), 0);
                    end else begin
                        e  = sb.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        chk("resp_valid", 64'(resp_valid), 64'(oh));
                        chk("resp_rdata", 64'(resp_rdata), 64'(e.rd));
                        chk("resp_err", 64'(resp_err), 64'(e.err));
                        chk("resp_cycle", 64'(cyc), 64'(e.due));
                    end
                end else if (sb.size() != 0 && cyc > sb[0].due) begin
                    chk("resp_missing", 64'(cyc), 64'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            pv[i] = 0;
            pw[i] = 0;
            pa[i] = '0;
            pd[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            lsu_mem[i] = ref_mem[i];
        end
        ref_mem[5] = 32'hDEADBEEF;
        lsu_mem[5] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        #1;
        outs_zero("reset");
        @(posedge clk);
        #2;
        rst    = 1'b0;
        in_rst = 0;

        // single load from requester 2
        set_mode(0, 0, 0);
        post(2, 0, 5, 0);
        drain(100);

        // store then load, requester 0, with a stray ready during ISSUE on the load
        post(0, 1, 9, 32'h12345678);
        drain(100);
        set_mode(1, 0, 1);
        post(0, 0, 9, 0);
        drain(100);

        // watchdog expiry, then a normal store and a ready on the last allowed cycle
        set_mode(0, 1, 0);
        post(1, 0, 3, 0);
        drain(100);
        set_mode(2, 0, 0);
        post(1, 1, 4, 32'hCAFE0001);
        drain(100);
        set_mode(TO - 1, 0, 0);
        post(3, 0, 4, 0);
        drain(100);

        // stray ready while idle
        @(negedge clk);
        #2 stray_idle = 1;
        @(negedge clk);
        #2 stray_idle = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("stray_idle_resp", 64'(resp_valid), 0);
        chk("stray_idle_strobe", 64'({lsu_mem_read, lsu_mem_write}), 0);
        set_mode(0, 0, 0);
        post(2, 0, 5, 0);
        drain(100);

        // randomized traffic
        set_mode(-1, -1, -1);
        gen_prob = 30;
        gen_left = 200;
        drain(20000);

        // reset while the LSU is still working on a load
        set_mode(10, 0, 0);
        post(3, 0, 7, 0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #2;
                n++;
            end while (sb.size() == 0 && n < 50);
            if (n >= 50) chk("rst_wait_accept", 64'(n), 0);
        end
        repeat (3) @(negedge clk);
        #3;
        in_rst = 1;
        rst    = 1'b1;
        #1;
        outs_zero("rst_wait");
        sb.delete();
        lq.delete();
        order.delete();
        ocyc.delete();
        last = N - 1;
        for (int i = 0; i < N; i++) post(i, bit'($urandom % 2), W'($urandom_range(0, 15)), $urandom);
        set_mode(0, 0, 0);
        gen_prob = 100;
        gen_left = 4;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_req_ready", 64'(req_ready), 0);
        chk("rst_hold_resp_valid", 64'(resp_valid), 0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        in_rst = 0;
        drain(200);

        // all requesters valid: strict rotation from 0, one grant per 3 cycles
        chk("rotation_count", 64'(order.size()), 8);
        for (int k = 0; k < order.size() && k < 8; k++) begin
            chk($sformatf("rotation_%0d", k), 64'(order[k]), 64'(k % N));
            if (k > 0) chk($sformatf("spacing_%0d", k), 64'(ocyc[k] - ocyc[k-1]), 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
